// File: rtl/ahb_sram_if.sv
// AHB-Lite bus bundle between a load-store master and the ahb_sram data memory.
interface ahb_sram_if;
  logic        hsel;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [2:0]  hburst;
  logic        hmastlock;
  logic [3:0]  hprot;
  logic [31:0] hwdata;
  logic        hready;
  logic        hreadyout;
  logic        hresp;
  logic [31:0] hrdata;

  modport master (
    output hsel, haddr, htrans, hwrite, hsize, hburst, hmastlock, hprot, hwdata, hready,
    input  hreadyout, hresp, hrdata
  );

  modport slave (
    input  hsel, haddr, htrans, hwrite, hsize, hburst, hmastlock, hprot, hwdata, hready,
    output hreadyout, hresp, hrdata
  );
endinterface

// File: rtl/ahb_sram.sv
// AHB-Lite word-organised data SRAM with lane writes, wait states and read-after-write bypass.
// Optional ERROR responses are built when AHB_SRAM_ERR_EN is defined.
module ahb_sram #(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_STATES = 0
) (
  input logic       clk,
  input logic       rst_n,
  ahb_sram_if.slave bus
);
  localparam int IDX_W = $clog2(DEPTH_WORDS);
  localparam int WS_M1 = (WAIT_STATES > 0) ? WAIT_STATES - 1 : 0;
  localparam logic [3:0] WS_LOAD = WS_M1[3:0];

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ERR1, ST_ERR2} state_t;

  function automatic logic [3:0] byte_en(input logic [2:0] size, input logic [1:0] lane);
    case (size)
      3'd0:    byte_en = 4'b0001 << lane;
      3'd1:    byte_en = lane[1] ? 4'b1100 : 4'b0011;
      default: byte_en = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] merge_lanes(input logic [31:0] old, input logic [31:0] wdat,
                                              input logic [3:0] be);
    merge_lanes = old;
    for (int b = 0; b < 4; b++)
      if (be[b]) merge_lanes[8*b +: 8] = wdat[8*b +: 8];
  endfunction

  logic [31:0]      mem [DEPTH_WORDS];
  state_t           state;
  logic [3:0]       cnt;
  logic             ready_q, resp_q;
  logic [31:0]      rdata_q;
  logic [IDX_W-1:0] idx_p1;
  logic [1:0]       lane_p1;
  logic [2:0]       size_p1;
  logic             wr_p1;

  logic             acc, err_a, acc_ok, acc_err, wr_done;
  logic [IDX_W-1:0] idx_a;
  logic [3:0]       be_p1;
  logic [31:0]      rd_word;
  logic             unused_bits;

  // Address phase: decode the incoming transfer
  assign acc   = bus.hsel & bus.htrans[1] & bus.hready;
  assign idx_a = bus.haddr[IDX_W+1:2];
`ifdef AHB_SRAM_ERR_EN
  assign err_a = (|bus.haddr[31:IDX_W+2]) | (bus.hsize > 3'd2) |
                 ((bus.hsize == 3'd1) & bus.haddr[0]) |
                 ((bus.hsize == 3'd2) & (|bus.haddr[1:0]));
`else
  assign err_a = 1'b0;
`endif
  assign acc_ok  = acc & ~err_a;
  assign acc_err = acc & err_a;

  assign unused_bits = ^{bus.hburst, bus.hmastlock, bus.hprot, bus.htrans[0],
                         bus.haddr[31:IDX_W+2]};

  // Data phase: a pending write retires on the edge where this slave is ready
  assign be_p1   = byte_en(size_p1, lane_p1);
  assign wr_done = wr_p1 & ready_q;
  assign rd_word = (wr_done && idx_p1 == idx_a) ? merge_lanes(mem[idx_a], bus.hwdata, be_p1)
                                                : mem[idx_a];

  always_ff @(posedge clk) begin
    if (wr_done)
      for (int b = 0; b < 4; b++)
        if (be_p1[b]) mem[idx_p1][8*b +: 8] <= bus.hwdata[8*b +: 8];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      cnt     <= 4'd0;
      ready_q <= 1'b1;
      resp_q  <= 1'b0;
      rdata_q <= 32'd0;
      idx_p1  <= '0;
      lane_p1 <= 2'd0;
      size_p1 <= 3'd0;
      wr_p1   <= 1'b0;
    end else begin
      if (ready_q) wr_p1 <= acc_ok & bus.hwrite;
      if (acc_ok) begin
        idx_p1  <= idx_a;
        lane_p1 <= bus.haddr[1:0];
        size_p1 <= bus.hsize;
        if (!bus.hwrite) rdata_q <= rd_word;
      end
      case (state)
        ST_IDLE, ST_ERR2: begin
          if (acc_err) begin
            state   <= ST_ERR1;
            ready_q <= 1'b0;
            resp_q  <= 1'b1;
          end else if (acc_ok && WAIT_STATES > 0) begin
            state   <= ST_WAIT;
            cnt     <= WS_LOAD;
            ready_q <= 1'b0;
            resp_q  <= 1'b0;
          end else begin
            state   <= ST_IDLE;
            ready_q <= 1'b1;
            resp_q  <= 1'b0;
          end
        end
        ST_WAIT: begin
          if (cnt == 4'd0) begin
            state   <= ST_IDLE;
            ready_q <= 1'b1;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        ST_ERR1: begin
          state   <= ST_ERR2;
          ready_q <= 1'b1;
          resp_q  <= 1'b1;
        end
        default: begin
          state   <= ST_IDLE;
          ready_q <= 1'b1;
          resp_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.hreadyout = ready_q;
  assign bus.hresp     = resp_q;
  assign bus.hrdata    = rdata_q;
endmodule

// File: tb/tb_ahb_sram.sv
// Directed bench for ahb_sram: zero-wait instance (a) and two-wait-state instance (b).
module tb_ahb_sram;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  ahb_sram_if ifa ();
  ahb_sram_if ifb ();
  assign ifa.hready = ifa.hreadyout;
  assign ifb.hready = ifb.hreadyout;

  ahb_sram #(.DEPTH_WORDS(16), .WAIT_STATES(0)) u_ws0 (.clk(clk), .rst_n(rst_n), .bus(ifa));
  ahb_sram #(.DEPTH_WORDS(16), .WAIT_STATES(2)) u_ws2 (.clk(clk), .rst_n(rst_n), .bus(ifb));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // drive an address phase on instance a (sel_b=0) or b (sel_b=1); act=0 issues IDLE
  task automatic addr_ph(input bit sel_b, input bit act, input bit wr, input logic [31:0] a,
                         input logic [2:0] sz);
    if (!sel_b) begin
      ifa.hsel = act; ifa.htrans = act ? 2'b10 : 2'b00; ifa.hwrite = wr;
      ifa.haddr = a; ifa.hsize = sz;
    end else begin
      ifb.hsel = act; ifb.htrans = act ? 2'b10 : 2'b00; ifb.hwrite = wr;
      ifb.haddr = a; ifb.hsize = sz;
    end
  endtask

  task automatic wdat(input bit sel_b, input logic [31:0] d);
    if (!sel_b) ifa.hwdata = d;
    else        ifb.hwdata = d;
  endtask

  initial begin
    ifa.hburst = 3'd0; ifa.hmastlock = 1'b0; ifa.hprot = 4'd0; ifa.hwdata = 32'd0;
    ifb.hburst = 3'd0; ifb.hmastlock = 1'b0; ifb.hprot = 4'd0; ifb.hwdata = 32'd0;
    addr_ph(0, 0, 0, 32'd0, 3'd0);
    addr_ph(1, 0, 0, 32'd0, 3'd0);
    repeat (3) step();
    chk("rst_rdy", {31'd0, ifa.hreadyout}, 32'd1);
    chk("rst_resp", {31'd0, ifa.hresp}, 32'd0);
    chk("rst_rdata", ifa.hrdata, 32'd0);
    rst_n = 1'b1;
    step();

    // word write then immediate read of the same word: bypass
    addr_ph(0, 1, 1, 32'h10, 3'd2);
    step();
    chk("ws0_rdy_w", {31'd0, ifa.hreadyout}, 32'd1);
    wdat(0, 32'hDEADBEEF);
    addr_ph(0, 1, 0, 32'h10, 3'd2);
    step();
    addr_ph(0, 0, 0, 32'd0, 3'd0);
    chk("bypass_word", ifa.hrdata, 32'hDEADBEEF);
    chk("ws0_rdy_r", {31'd0, ifa.hreadyout}, 32'd1);
    step();

    // byte and halfword lane writes
    addr_ph(0, 1, 1, 32'h20, 3'd2);
    step();
    wdat(0, 32'h11223344);
    addr_ph(0, 1, 1, 32'h23, 3'd0);
    step();
    wdat(0, 32'hAA000000);
    addr_ph(0, 1, 0, 32'h20, 3'd2);
    step();
    chk("byte3", ifa.hrdata, 32'hAA223344);
    addr_ph(0, 1, 1, 32'h22, 3'd1);
    step();
    wdat(0, 32'h55660000);
    addr_ph(0, 1, 0, 32'h20, 3'd2);
    step();
    chk("half_hi", ifa.hrdata, 32'h55663344);
    addr_ph(0, 1, 1, 32'h20, 3'd1);
    step();
    wdat(0, 32'h00007788);
    addr_ph(0, 1, 1, 32'h21, 3'd0);
    step();
    wdat(0, 32'h00009900);
    addr_ph(0, 0, 0, 32'd0, 3'd0);
    step();
    addr_ph(0, 1, 0, 32'h20, 3'd2);
    step();
    addr_ph(0, 0, 0, 32'd0, 3'd0);
    chk("half_lo_byte1", ifa.hrdata, 32'h55669988);

    // out-of-range write: error or wrap depending on build
    addr_ph(0, 1, 1, 32'h0, 3'd2);
    step();
    wdat(0, 32'h01020304);
    addr_ph(0, 1, 1, 32'h40, 3'd2);
    step();
    wdat(0, 32'hCAFEF00D);
`ifdef AHB_SRAM_ERR_EN
    addr_ph(0, 0, 0, 32'd0, 3'd0);
    chk("err1_rdy", {31'd0, ifa.hreadyout}, 32'd0);
    chk("err1_resp", {31'd0, ifa.hresp}, 32'd1);
    step();
    chk("err2_rdy", {31'd0, ifa.hreadyout}, 32'd1);
    chk("err2_resp", {31'd0, ifa.hresp}, 32'd1);
    step();
    chk("post_err_resp", {31'd0, ifa.hresp}, 32'd0);
    addr_ph(0, 1, 0, 32'h0, 3'd2);
    step();
    addr_ph(0, 0, 0, 32'd0, 3'd0);
    chk("err_no_write", ifa.hrdata, 32'h01020304);
    addr_ph(0, 1, 0, 32'h2, 3'd2);
    step();
    addr_ph(0, 0, 0, 32'd0, 3'd0);
    chk("mis_err1_rdy", {31'd0, ifa.hreadyout}, 32'd0);
    chk("mis_err1_resp", {31'd0, ifa.hresp}, 32'd1);
    step();
    chk("mis_err2_rdy", {31'd0, ifa.hreadyout}, 32'd1);
    chk("mis_err2_resp", {31'd0, ifa.hresp}, 32'd1);
    step();
    chk("mis_rdata_held", ifa.hrdata, 32'h01020304);
`else
    addr_ph(0, 1, 0, 32'h0, 3'd2);
    chk("wrap_resp", {31'd0, ifa.hresp}, 32'd0);
    step();
    addr_ph(0, 0, 0, 32'd0, 3'd0);
    chk("wrap_bypass", ifa.hrdata, 32'hCAFEF00D);
    step();
    addr_ph(0, 1, 0, 32'h0, 3'd2);
    step();
    addr_ph(0, 0, 0, 32'd0, 3'd0);
    chk("wrap_mem", ifa.hrdata, 32'hCAFEF00D);
    chk("wrap_resp2", {31'd0, ifa.hresp}, 32'd0);
`endif
    step();

    // two wait states: write then read
    addr_ph(1, 1, 1, 32'h4, 3'd2);
    step();
    wdat(1, 32'h13572468);
    addr_ph(1, 0, 0, 32'd0, 3'd0);
    chk("ws2_w_c1", {31'd0, ifb.hreadyout}, 32'd0);
    step();
    chk("ws2_w_c2", {31'd0, ifb.hreadyout}, 32'd0);
    step();
    chk("ws2_w_c3", {31'd0, ifb.hreadyout}, 32'd1);
    step();
    addr_ph(1, 1, 0, 32'h4, 3'd2);
    step();
    addr_ph(1, 0, 0, 32'd0, 3'd0);
    chk("ws2_r_c1", {31'd0, ifb.hreadyout}, 32'd0);
    step();
    chk("ws2_r_c2", {31'd0, ifb.hreadyout}, 32'd0);
    step();
    chk("ws2_r_c3", {31'd0, ifb.hreadyout}, 32'd1);
    chk("ws2_rdata", ifb.hrdata, 32'h13572468);
    step();

    // reset in the middle of a write's wait states
    addr_ph(1, 1, 1, 32'h4, 3'd2);
    step();
    wdat(1, 32'hFFFFFFFF);
    addr_ph(1, 0, 0, 32'd0, 3'd0);
    chk("rw_wait", {31'd0, ifb.hreadyout}, 32'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("rw_rst_rdy", {31'd0, ifb.hreadyout}, 32'd1);
    chk("rw_rst_resp", {31'd0, ifb.hresp}, 32'd0);
    chk("rw_rst_rdata", ifb.hrdata, 32'd0);
    step();
    step();
    rst_n = 1'b1;
    step();
    chk("rw_post_rdy", {31'd0, ifb.hreadyout}, 32'd1);
    addr_ph(1, 1, 0, 32'h4, 3'd2);
    step();
    addr_ph(1, 0, 0, 32'd0, 3'd0);
    step();
    step();
    chk("rw_unchanged", ifb.hrdata, 32'h13572468);
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
